// File: rtl/stack_fifo_buf_pkg.sv
// Shared types and modulo-depth pointer helpers for the LIFO/FIFO buffer.
// Latency: none (pure functions and types only).
// Backpressure: not applicable.
package stack_pkg;

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } stk_mode_t;

    // Advance a pointer by one, wrapping explicitly from depth-1 to 0.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] res;
        if (ptr == depth - 32'd1) res = 32'd0;
        else                      res = ptr + 32'd1;
        return res;
    endfunction

    // Step a pointer back by one, wrapping explicitly from 0 to depth-1.
    function automatic logic [31:0] ptr_dec(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] res;
        if (ptr == 32'd0) res = depth - 32'd1;
        else              res = ptr - 32'd1;
        return res;
    endfunction

    // (ptr + off) mod depth for ptr < depth and off <= depth: one subtract suffices.
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr, input logic [31:0] off,
                                            input logic [31:0] depth);
        logic [31:0] sum;
        sum = ptr + off;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

endpackage

// File: rtl/stack_fifo_buf_if.sv
// Request/response bundle between a buffer user and stack_fifo_buf.
// Latency: wiring only.
// Backpressure: user watches o_full/o_empty; rejected requests raise sticky flags.
interface stack_fifo_buf_if #(
    parameter int DPT = 4,
    parameter int DW  = 8
);
    import stack_pkg::*;

    localparam int CNTW = $clog2(DPT + 1);

    logic            i_clr;
    logic            i_mode;
    logic            i_push_en;
    logic [DW-1:0]   i_push_data;
    logic            i_pop_en;
    logic [DW-1:0]   o_pop_data;
    logic            o_full;
    logic            o_afull;
    logic            o_empty;
    logic            o_aempty;
    logic [CNTW-1:0] o_count;
    stk_mode_t       o_mode;
    logic            o_ovf;
    logic            o_udf;

    modport master (
        output i_clr, i_mode, i_push_en, i_push_data, i_pop_en,
        input  o_pop_data, o_full, o_afull, o_empty, o_aempty, o_count, o_mode, o_ovf, o_udf
    );

    modport slave (
        input  i_clr, i_mode, i_push_en, i_push_data, i_pop_en,
        output o_pop_data, o_full, o_afull, o_empty, o_aempty, o_count, o_mode, o_ovf, o_udf
    );

endinterface

// File: rtl/stack_fifo_buf_ram.sv
// DPT x DW storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the clock edge; read is combinational.
// Backpressure: none; unreset so it maps onto LUT RAM.
module stack_ram #(
    parameter int DPT  = 4,
    parameter int DW   = 8,
    parameter int PTRW = $clog2(DPT)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PTRW-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [PTRW-1:0] raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DPT];

    // Single write port; addresses are always kept below DPT by the controller.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_fifo_buf.sv
// Runtime-selectable LIFO/FIFO buffer with occupancy, thresholds and sticky error flags.
// Latency: push visible on o_pop_data one cycle later; pop data combinational from state.
// Backpressure: push while full rejected (unless paired with a pop) -> o_ovf; pop while empty -> o_udf.
module stack_fifo_buf #(
    parameter int DPT       = 4,
    parameter int DW        = 8,
    parameter int AFULL_TH  = DPT - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic             clk,
    input  logic             aresetn,
    stack_fifo_buf_if.slave  bus
);
    import stack_pkg::*;

    localparam int PTRW = $clog2(DPT);
    localparam int CNTW = $clog2(DPT + 1);

    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(DPT);
    localparam logic [CNTW-1:0] AF_LEVEL = CNTW'(AFULL_TH);
    localparam logic [CNTW-1:0] AE_LEVEL = CNTW'(AEMPTY_TH);

    logic [PTRW-1:0] base_ff, base_nxt;
    logic [CNTW-1:0] cnt_ff,  cnt_nxt;
    stk_mode_t       mode_ff, mode_nxt;
    logic            ovf_ff,  ovf_nxt;
    logic            udf_ff,  udf_nxt;

    logic            full, empty;
    logic            pop_ok, push_ok;
    logic [PTRW-1:0] tail_ptr, top_ptr, base_inc;
    logic [PTRW-1:0] rd_addr, wr_addr;
    logic            wr_en;
    logic [DW-1:0]   rd_data;

    assign full  = (cnt_ff == CNT_MAX);
    assign empty = (cnt_ff == '0);

    // A push into a full buffer is fine when a pop frees the slot in the same cycle.
    assign pop_ok  = bus.i_pop_en & ~empty;
    assign push_ok = bus.i_push_en & (~full | pop_ok);

    // Pointer decode: tail is the next free slot, top is the newest entry.
    always_comb begin
        tail_ptr = PTRW'(ptr_add(32'(base_ff), 32'(cnt_ff), 32'(DPT)));
        top_ptr  = PTRW'(ptr_dec(32'(tail_ptr), 32'(DPT)));
        base_inc = PTRW'(ptr_inc(32'(base_ff), 32'(DPT)));
        rd_addr  = (mode_ff == MODE_FIFO) ? base_ff : top_ptr;
        // LIFO push+pop replaces the top in place; everything else appends at the tail.
        if ((mode_ff == MODE_LIFO) && push_ok && pop_ok) wr_addr = top_ptr;
        else                                             wr_addr = tail_ptr;
        wr_en = push_ok & ~bus.i_clr;
    end

    // Next-state for count, base, mode and sticky flags; clear overrides all traffic.
    always_comb begin
        base_nxt = base_ff;
        cnt_nxt  = cnt_ff;
        mode_nxt = mode_ff;
        ovf_nxt  = ovf_ff;
        udf_nxt  = udf_ff;
        if (bus.i_clr) begin
            base_nxt = '0;
            cnt_nxt  = '0;
            mode_nxt = stk_mode_t'(bus.i_mode);
            ovf_nxt  = 1'b0;
            udf_nxt  = 1'b0;
        end else begin
            if (push_ok && !pop_ok) begin
                cnt_nxt = cnt_ff + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_nxt = cnt_ff - 1'b1;
                if (mode_ff == MODE_FIFO) base_nxt = base_inc;
            end else if (pop_ok && push_ok) begin
                if (mode_ff == MODE_FIFO) base_nxt = base_inc;
            end
            if (bus.i_push_en && !push_ok) ovf_nxt = 1'b1;
            if (bus.i_pop_en && empty)     udf_nxt = 1'b1;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            base_ff <= '0;
            cnt_ff  <= '0;
            mode_ff <= MODE_LIFO;
            ovf_ff  <= 1'b0;
            udf_ff  <= 1'b0;
        end else begin
            base_ff <= base_nxt;
            cnt_ff  <= cnt_nxt;
            mode_ff <= mode_nxt;
            ovf_ff  <= ovf_nxt;
            udf_ff  <= udf_nxt;
        end
    end

    stack_ram #(
        .DPT  (DPT),
        .DW   (DW),
        .PTRW (PTRW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.i_push_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign bus.o_pop_data = rd_data;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_afull    = (cnt_ff >= AF_LEVEL);
    assign bus.o_aempty   = (cnt_ff <= AE_LEVEL);
    assign bus.o_count    = cnt_ff;
    assign bus.o_mode     = mode_ff;
    assign bus.o_ovf      = ovf_ff;
    assign bus.o_udf      = udf_ff;

endmodule

// File: tb/tb_stack_fifo_buf.sv
// Directed bench for stack_fifo_buf (DPT=4, DW=8, AFULL_TH=3, AEMPTY_TH=1).
// Latency: checks taken 1 time unit after the active edge.
// Backpressure: exercises full/empty rejection and sticky flags.
module tb_stack_fifo_buf;

    logic clk;
    logic aresetn;
    int   n_vec;
    int   n_err;

    stack_fifo_buf_if #(.DPT(4), .DW(8)) bus ();

    stack_fifo_buf #(
        .DPT       (4),
        .DW        (8),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clocked operation; inputs return to idle just after the edge.
    task automatic do_op(input logic push, input logic [7:0] d, input logic pop,
                         input logic clr, input logic mode);
        bus.i_push_en   = push;
        bus.i_push_data = d;
        bus.i_pop_en    = pop;
        bus.i_clr       = clr;
        bus.i_mode      = mode;
        @(posedge clk);
        #1;
        bus.i_push_en   = 1'b0;
        bus.i_pop_en    = 1'b0;
        bus.i_clr       = 1'b0;
        bus.i_mode      = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        do_op(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    // Check the combinational pop data, then pop it.
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 32'(bus.o_pop_data), 32'(exp));
        do_op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        aresetn         = 1'b0;
        bus.i_clr       = 1'b0;
        bus.i_mode      = 1'b0;
        bus.i_push_en   = 1'b0;
        bus.i_push_data = 8'h00;
        bus.i_pop_en    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;

        // Reset state
        chk("rst_count",  32'(bus.o_count),  32'd0);
        chk("rst_empty",  32'(bus.o_empty),  32'd1);
        chk("rst_aempty", 32'(bus.o_aempty), 32'd1);
        chk("rst_full",   32'(bus.o_full),   32'd0);
        chk("rst_afull",  32'(bus.o_afull),  32'd0);
        chk("rst_mode",   32'(bus.o_mode),   32'd0);
        chk("rst_ovf",    32'(bus.o_ovf),    32'd0);
        chk("rst_udf",    32'(bus.o_udf),    32'd0);

        // LIFO basic order
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("lifo_count3", 32'(bus.o_count), 32'd3);
        pop_chk("lifo_pop0", 8'h33);
        pop_chk("lifo_pop1", 8'h22);
        pop_chk("lifo_pop2", 8'h11);
        chk("lifo_empty", 32'(bus.o_empty), 32'd1);
        chk("lifo_udf0",  32'(bus.o_udf),   32'd0);

        // Thresholds while filling 0 -> 4
        chk("th0_aempty", 32'(bus.o_aempty), 32'd1);
        chk("th0_afull",  32'(bus.o_afull),  32'd0);
        push(8'h41);
        chk("th1_aempty", 32'(bus.o_aempty), 32'd1);
        chk("th1_afull",  32'(bus.o_afull),  32'd0);
        push(8'h42);
        chk("th2_aempty", 32'(bus.o_aempty), 32'd0);
        chk("th2_afull",  32'(bus.o_afull),  32'd0);
        push(8'h43);
        chk("th3_aempty", 32'(bus.o_aempty), 32'd0);
        chk("th3_afull",  32'(bus.o_afull),  32'd1);
        chk("th3_full",   32'(bus.o_full),   32'd0);
        push(8'h44);
        chk("th4_afull",  32'(bus.o_afull),  32'd1);
        chk("th4_full",   32'(bus.o_full),   32'd1);
        chk("th4_top",    32'(bus.o_pop_data), 32'h44);

        // LIFO full: push+pop replaces top
        do_op(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        chk("lfull_pp_count", 32'(bus.o_count),    32'd4);
        chk("lfull_pp_top",   32'(bus.o_pop_data), 32'h99);
        chk("lfull_pp_ovf",   32'(bus.o_ovf),      32'd0);

        // Overflow: push while full, no pop
        push(8'h55);
        chk("ovf_set",   32'(bus.o_ovf),      32'd1);
        chk("ovf_count", 32'(bus.o_count),    32'd4);
        chk("ovf_top",   32'(bus.o_pop_data), 32'h99);
        pop_chk("ldrain0", 8'h99);
        pop_chk("ldrain1", 8'h43);
        pop_chk("ldrain2", 8'h42);
        pop_chk("ldrain3", 8'h41);
        chk("ldrain_empty", 32'(bus.o_empty), 32'd1);

        // Underflow: pop while empty; overflow still held
        do_op(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("udf_set",   32'(bus.o_udf),   32'd1);
        chk("udf_count", 32'(bus.o_count), 32'd0);
        chk("ovf_hold",  32'(bus.o_ovf),   32'd1);

        // Push+pop while empty: push only
        do_op(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        chk("epp_count", 32'(bus.o_count),    32'd1);
        chk("epp_data",  32'(bus.o_pop_data), 32'h66);
        chk("epp_udf",   32'(bus.o_udf),      32'd1);

        // Clear into FIFO mode
        do_op(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("clr_count", 32'(bus.o_count), 32'd0);
        chk("clr_ovf",   32'(bus.o_ovf),   32'd0);
        chk("clr_udf",   32'(bus.o_udf),   32'd0);
        chk("clr_mode",  32'(bus.o_mode),  32'd1);
        chk("clr_empty", 32'(bus.o_empty), 32'd1);

        // FIFO wrap
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        chk("f_full0", 32'(bus.o_full), 32'd1);
        pop_chk("f_pop0", 8'hA0);
        pop_chk("f_pop1", 8'hA1);
        chk("f_count2", 32'(bus.o_count), 32'd2);
        push(8'hA4);
        push(8'hA5);
        chk("f_full1", 32'(bus.o_full), 32'd1);
        pop_chk("f_pop2", 8'hA2);
        pop_chk("f_pop3", 8'hA3);
        pop_chk("f_pop4", 8'hA4);
        pop_chk("f_pop5", 8'hA5);
        chk("f_empty", 32'(bus.o_empty), 32'd1);

        // FIFO full: push+pop pops head, appends at tail
        push(8'hB0);
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        chk("ffull_head", 32'(bus.o_pop_data), 32'hB0);
        do_op(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        chk("ffull_pp_count", 32'(bus.o_count), 32'd4);
        chk("ffull_pp_ovf",   32'(bus.o_ovf),   32'd0);
        pop_chk("fdrain0", 8'hB1);
        pop_chk("fdrain1", 8'hB2);
        pop_chk("fdrain2", 8'hB3);
        pop_chk("fdrain3", 8'h99);
        chk("fdrain_empty", 32'(bus.o_empty), 32'd1);

        // Asynchronous reset mid-operation at count=2
        push(8'hC0);
        push(8'hC1);
        chk("pre_rst_count", 32'(bus.o_count), 32'd2);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_count",  32'(bus.o_count),  32'd0);
        chk("arst_empty",  32'(bus.o_empty),  32'd1);
        chk("arst_aempty", 32'(bus.o_aempty), 32'd1);
        chk("arst_mode",   32'(bus.o_mode),   32'd0);
        chk("arst_full",   32'(bus.o_full),   32'd0);
        @(negedge clk);
        aresetn = 1'b1;

        // Clear with concurrent push / pop is ignored and raises no flag
        push(8'h77);
        chk("pre_clr_count", 32'(bus.o_count), 32'd1);
        do_op(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        chk("clrpush_count", 32'(bus.o_count), 32'd0);
        chk("clrpush_empty", 32'(bus.o_empty), 32'd1);
        chk("clrpush_ovf",   32'(bus.o_ovf),   32'd0);
        do_op(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("clrpop_udf",    32'(bus.o_udf),   32'd0);
        chk("clrpop_mode",   32'(bus.o_mode),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stack_fifo_buf.md
# stack_fifo_buf

Parametrised LIFO/FIFO buffer with runtime mode selection, occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags. It succeeds the plain LIFO stack and is used wherever a small ordered store is needed: return-address stacks, operand stacks, or shallow queues. Storage is a circular array with one write port and one asynchronous read port, mappable to LUT RAM.

## Interface
- `DPT`, default 4: depth in entries; ≥2; any value, not just powers of two.
- `DW`, default 8: data width.
- `AFULL_TH`, default DPT-1: `o_afull` asserts when count ≥ AFULL_TH.
- `AEMPTY_TH`, default 1: `o_aempty` asserts when count ≤ AEMPTY_TH.
- Parameter constraint: 0 ≤ AEMPTY_TH < AFULL_TH ≤ DPT.
- Localparams: `PTRW` = $clog2(DPT); `CNTW` = $clog2(DPT+1).

Ports:
- `clk`, in, 1: clock; the block has one clock.
- `aresetn`, in, 1: reset; asynchronous, active-low.
- `i_clr`, in, 1: synchronous flush; also latches `i_mode`.
- `i_mode`, in, 1: 0 = LIFO, 1 = FIFO; sampled only when `i_clr`=1.
- `i_push_en`, in, 1: push request.
- `i_push_data`, in, DW: push data.
- `o_full`, out, 1: count == DPT.
- `o_afull`, out, 1: almost full.
- `i_pop_en`, in, 1: pop request.
- `o_pop_data`, out, DW: LIFO top or FIFO head; valid only when `o_empty`=0.
- `o_empty`, out, 1: count == 0.
- `o_aempty`, out, 1: almost empty.
- `o_count`, out, CNTW: current occupancy, 0..DPT.
- `o_mode`, out, 1: active mode.
- `o_ovf`, out, 1: sticky overflow flag.
- `o_udf`, out, 1: sticky underflow flag.

## Operation
- State: `base_ff` (PTRW bits), `cnt_ff` (CNTW bits), `mode_ff`, `ovf_ff`, `udf_ff`. The storage array is not reset.
- Pointer arithmetic is modulo DPT with explicit wrap (DPT-1 → 0); never rely on binary overflow.
- Write address: (base + cnt) mod DPT in both modes, except for a LIFO simultaneous push and pop (see below).
- Read address: LIFO uses (base + cnt − 1) mod DPT; FIFO uses base.
- Accepted pop: `pop_ok` = `i_pop_en` & ~empty.
- Accepted push: `push_ok` = `i_push_en` & (~full | `pop_ok`). A push while full is accepted only together with a pop.
- Push only: cnt+1.
- Pop only: cnt−1. In FIFO mode, base also advances by 1 with wrap.
- Push and pop together, LIFO: the top entry is overwritten at the read address; cnt and base are unchanged.
- Push and pop together, FIFO: head is popped, base advances by 1, new data is written at the old (base + cnt) mod DPT; cnt is unchanged.
- Push and pop while empty: the pop is rejected and the push proceeds as a push only; `o_udf` sets.
- `o_ovf` sets on `i_push_en` & ~`push_ok`.
- `o_udf` sets on `i_pop_en` & empty.
- Both error flags hold until `i_clr` or reset.
- `i_clr`=1 takes priority over everything: cnt=0, base=0, ovf=udf=0, `mode_ff`=`i_mode`. Any push or pop in that cycle is ignored and does not set the error flags.
- The mode can change only through `i_clr`, so contents are never reinterpreted.

## Timing
- Reset values: cnt=0, base=0, `o_mode`=LIFO, `o_empty`=1, `o_aempty`=1, `o_full`=0, `o_afull`=0, `o_ovf`=0, `o_udf`=0. `o_pop_data` is undefined.
- State updates on the rising `clk` edge. Reset asserting mid-operation clears all state immediately; prior contents are lost logically.
- Push-to-visible latency: 1 cycle. Data pushed at edge N appears on `o_pop_data` after edge N if it becomes the top/head.
- Pop data is combinational from the current state. The consumer samples `o_pop_data` in the same cycle it asserts `i_pop_en`.
- All flags and `o_count` are decoded from registered state: no combinational path from `i_push_en`/`i_pop_en` to any output.

## Structure
- Package `stack_pkg` holds `typedef enum logic {MODE_LIFO=1'b0, MODE_FIFO=1'b1} stk_mode_t` and a wrap-increment/decrement function for modulo-DPT pointers.
- Sub-module `stack_ram`: DPT×DW array with one synchronous write port and one asynchronous read port. It has no reset so it infers LUT RAM.
- Top level contains the control: pointers, count, flags, mode.

## Test plan
- Reset, then LIFO (DPT=4): push 0x11, 0x22, 0x33 → count=3, `o_pop_data`=0x33; pop three times → data 0x33, 0x22, 0x11; then `o_empty`=1.
- Clear with `i_mode`=1, then FIFO wrap: push A0..A3, pop 2, push A4, A5 → `o_full`=1; pop sequence A2, A3, A4, A5 confirms base wraps 3→0.
- Full, push+pop together: LIFO full with top 0x44, push 0x99 and pop → count stays 4, top becomes 0x99, `o_ovf`=0. FIFO full: head pops, tail receives 0x99.
- Errors: push while full without a pop → `o_ovf`=1 and count unchanged; pop while empty → `o_udf`=1; both hold until `i_clr`, then read 0.
- Thresholds (AFULL_TH=3, AEMPTY_TH=1): count 0→4 → `o_aempty`=1 at 0 and 1, 0 at 2; `o_afull`=1 at 3 and 4.
- Mid-operation reset and clear: drop `aresetn` at count=2 → all outputs take reset values asynchronously. `i_clr` together with a push → count=0 and the push is ignored.
